// File: rtl/core_regs_wb_arbiter_pkg.sv
// Shared writeback types for the register-file write-port arbiter.
package core_regs_wb_arbiter_pkg;

  typedef logic [4:0]  reg_num;
  typedef logic [31:0] word;

  typedef struct packed {
    logic   ready;
    reg_num rd;
    word    value;
  } wb_line;

  localparam reg_num R0         = 5'd0;
  localparam int     NUM_WB_SRC = 4;

  typedef enum logic [1:0] {
    WB_ALU_A,
    WB_ALU_B,
    WB_MUL,
    WB_LDST
  } wb_src_e;

  localparam wb_line WB_IDLE = '{ready: 1'b0, rd: R0, value: '0};

endpackage

// File: rtl/core_regs_wb_rr_pick.sv
// Round-robin pick of two requesters; the second must not share the first's rd.
module core_regs_wb_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic [N-1:0][N-1:0] same_rd,
  output logic [N-1:0]        grant_a,
  output logic [N-1:0]        grant_b
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] idx;
  logic [PW-1:0] a_idx;
  logic          found_a;
  logic          found_b;

  always_comb begin
    grant_a = '0;
    grant_b = '0;
    idx     = '0;
    a_idx   = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (req[idx] && !found_a) begin
        grant_a[idx] = 1'b1;
        a_idx        = idx;
        found_a      = 1'b1;
      end
    end
    // Entries ahead of a_idx in scan order were not requesting, so a full rescan is equivalent.
    for (int k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (found_a && !found_b && req[idx] && idx != a_idx && !same_rd[a_idx][idx]) begin
        grant_b[idx] = 1'b1;
        found_b      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_regs_wb_arbiter.sv
// Shares the two core_regs write ports among NUM_SRC buffered writeback sources.
// CORE_WB_BYPASS_EN: empty buffers with a valid source join arbitration directly (1-cycle latency).
module core_regs_wb_arbiter
  import core_regs_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_WB_SRC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  reg_num [NUM_SRC-1:0] src_rd,
  input  word [NUM_SRC-1:0]    src_value,
  output logic [NUM_SRC-1:0]   src_ready,
  output wb_line               wr_a,
  output wb_line               wr_b,
  output logic                 busy
);
  localparam int PW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]              occ, byp, req, pick_a, pick_b;
  logic [NUM_SRC-1:0]              grant_a, grant_b, grant, store;
  reg_num [NUM_SRC-1:0]            buf_rd, cand_rd;
  word [NUM_SRC-1:0]               buf_val, cand_val;
  logic [NUM_SRC-1:0][NUM_SRC-1:0] same_rd;
  logic [PW-1:0]                   rr, rr_next, idx_a, idx_b, idx_last;
  wb_line                          line_a, line_b;

  always_comb begin
`ifdef CORE_WB_BYPASS_EN
    byp = src_valid & ~occ;
`else
    byp = '0;
`endif
    req = occ | byp;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand_rd[i]  = occ[i] ? buf_rd[i]  : src_rd[i];
      cand_val[i] = occ[i] ? buf_val[i] : src_value[i];
    end
    for (int i = 0; i < NUM_SRC; i++)
      for (int j = 0; j < NUM_SRC; j++)
        same_rd[i][j] = (cand_rd[i] == cand_rd[j]);
  end

  core_regs_wb_rr_pick #(.N(NUM_SRC)) u_pick (
    .req     (req),
    .ptr     (rr),
    .same_rd (same_rd),
    .grant_a (pick_a),
    .grant_b (pick_b)
  );

  always_comb begin
    grant_a   = flush ? '0 : pick_a;
    grant_b   = flush ? '0 : pick_b;
    grant     = grant_a | grant_b;
    src_ready = flush ? '0 : (~occ | grant);
    // A bypassed transfer completes through the port register and never lands in the buffer.
    store     = src_valid & src_ready & ~(grant & byp);
    line_a    = WB_IDLE;
    line_b    = WB_IDLE;
    idx_a     = '0;
    idx_b     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_a[i]) begin
        line_a = '{ready: 1'b1, rd: cand_rd[i], value: cand_val[i]};
        idx_a  = PW'(i);
      end
      if (grant_b[i]) begin
        line_b = '{ready: 1'b1, rd: cand_rd[i], value: cand_val[i]};
        idx_b  = PW'(i);
      end
    end
    idx_last = (|grant_b) ? idx_b : idx_a;
    rr_next  = PW'((32'(idx_last) + 1) % NUM_SRC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ     <= '0;
      buf_rd  <= '0;
      buf_val <= '0;
      rr      <= '0;
      wr_a    <= WB_IDLE;
      wr_b    <= WB_IDLE;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (flush) occ[i] <= 1'b0;
        else       occ[i] <= (occ[i] & ~grant[i]) | store[i];
        if (store[i]) begin
          buf_rd[i]  <= src_rd[i];
          buf_val[i] <= src_value[i];
        end
      end
      wr_a <= line_a;
      wr_b <= line_b;
      if (|grant) rr <= rr_next;
    end
  end

  assign busy = |occ;

endmodule

// File: tb/tb_core_regs_wb_arbiter.sv
// Self-checking bench for core_regs_wb_arbiter: directed scenarios plus a random run against a queue-based model.
module tb_core_regs_wb_arbiter;
  import core_regs_wb_arbiter_pkg::*;

`ifdef CORE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk, rst_n, flush;
  logic [3:0] src_valid;
  reg_num [3:0] src_rd;
  word [3:0]  src_value;
  logic [3:0] src_ready;
  wb_line     wr_a, wr_b;
  logic       busy;

  int total = 0;
  int bad   = 0;

  core_regs_wb_arbiter #(.NUM_SRC(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .src_valid (src_valid),
    .src_rd    (src_rd),
    .src_value (src_value),
    .src_ready (src_ready),
    .wr_a      (wr_a),
    .wr_b      (wr_b),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush     = 1'b0;
    src_valid = '0;
    src_rd    = '0;
    src_value = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (wr_a !== WB_IDLE) begin bad++; $display("FAIL reset_wr_a got=%h want=%h", wr_a, WB_IDLE); end
    total++; if (wr_b !== WB_IDLE) begin bad++; $display("FAIL reset_wr_b got=%h want=%h", wr_b, WB_IDLE); end
    total++; if (src_ready !== 4'b1111) begin bad++; $display("FAIL reset_src_ready got=%b want=1111", src_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    tick();
  endtask

  task automatic test_single();
    int s;
    s = int'(WB_MUL);
    do_reset();
    src_valid[s] = 1'b1; src_rd[s] = 5'd5; src_value[s] = 32'hDEADBEEF;
    @(negedge clk);
    total++; if (src_ready !== 4'b1111) begin bad++; $display("FAIL single_ready0 got=%b want=1111", src_ready); end
    tick();
    clear_inputs();
    @(negedge clk);
    total++; if (busy !== 1'b1 || wr_a.ready !== 1'b0) begin bad++; $display("FAIL single_cycle1 got busy=%b a.ready=%b want busy=1 a.ready=0", busy, wr_a.ready); end
    tick();
    @(negedge clk);
    total++; if (wr_a !== '{1'b1, 5'd5, 32'hDEADBEEF}) begin bad++; $display("FAIL single_wr_a got=%h want=1/05/deadbeef", wr_a); end
    total++; if (wr_b !== WB_IDLE) begin bad++; $display("FAIL single_wr_b got=%h want=idle", wr_b); end
    total++; if (dut.rr !== 2'd3) begin bad++; $display("FAIL single_rr got=%0d want=3", dut.rr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", busy); end
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_valid[i] = 1'b1; src_rd[i] = reg_num'(i + 1); src_value[i] = 32'h100 + i;
    end
    tick();
    clear_inputs();
    @(negedge clk);
    total++; if (src_ready !== 4'b0011) begin bad++; $display("FAIL cont_ready1 got=%b want=0011", src_ready); end
    tick();
    @(negedge clk);
    total++; if (wr_a !== '{1'b1, 5'd1, 32'h100} || wr_b !== '{1'b1, 5'd2, 32'h101}) begin bad++; $display("FAIL cont_cycle2 got a=%h b=%h want rd1/rd2", wr_a, wr_b); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL cont_busy2 got=%b want=1", busy); end
    tick();
    @(negedge clk);
    total++; if (wr_a !== '{1'b1, 5'd3, 32'h102} || wr_b !== '{1'b1, 5'd4, 32'h103}) begin bad++; $display("FAIL cont_cycle3 got a=%h b=%h want rd3/rd4", wr_a, wr_b); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_busy3 got=%b want=0", busy); end
    tick();
    @(negedge clk);
    total++; if (wr_a.ready !== 1'b0 || wr_b.ready !== 1'b0) begin bad++; $display("FAIL cont_idle4 got a=%b b=%b want 0/0", wr_a.ready, wr_b.ready); end
  endtask

  task automatic test_rd_conflict();
    do_reset();
    src_valid = 4'b0111;
    src_rd[0] = 5'd7; src_value[0] = 32'hA0;
    src_rd[1] = 5'd7; src_value[1] = 32'hA1;
    src_rd[2] = 5'd8; src_value[2] = 32'hA2;
    tick();
    clear_inputs();
    tick();
    @(negedge clk);
    total++; if (wr_a !== '{1'b1, 5'd7, 32'hA0} || wr_b !== '{1'b1, 5'd8, 32'hA2}) begin bad++; $display("FAIL conflict_first got a=%h b=%h want src0 rd7 / src2 rd8", wr_a, wr_b); end
    tick();
    @(negedge clk);
    total++; if (wr_a !== '{1'b1, 5'd7, 32'hA1} || wr_b !== WB_IDLE) begin bad++; $display("FAIL conflict_second got a=%h b=%h want src1 rd7 / idle", wr_a, wr_b); end
    tick();
  endtask

  task automatic test_refill();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      src_valid[3] = 1'b1; src_rd[3] = 5'd9; src_value[3] = 32'h5000 + k;
      @(negedge clk);
      total++; if (src_ready !== 4'b1111) begin bad++; $display("FAIL refill_ready k=%0d got=%b want=1111", k, src_ready); end
      if (k >= 2) begin
        total++;
        if (wr_a !== '{1'b1, 5'd9, 32'h5000 + k - 2} || wr_b.ready !== 1'b0) begin
          bad++; $display("FAIL refill_port k=%0d got a=%h b.ready=%b want value=%h", k, wr_a, wr_b.ready, 32'h5000 + k - 2);
        end
      end
      tick();
    end
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_flush();
    do_reset();
    src_valid[1] = 1'b1; src_rd[1] = 5'd11; src_value[1] = 32'hB1;
    tick();
    src_valid = 4'b1101;
    src_rd[0] = 5'd12; src_value[0] = 32'hC0;
    src_rd[2] = 5'd13; src_value[2] = 32'hC2;
    src_rd[3] = 5'd14; src_value[3] = 32'hC3;
    src_valid[1] = 1'b0;
    tick();
    clear_inputs();
    flush = 1'b1;
    @(negedge clk);
    total++; if (src_ready !== 4'b0000) begin bad++; $display("FAIL flush_ready got=%b want=0000", src_ready); end
    total++; if (wr_a !== '{1'b1, 5'd11, 32'hB1}) begin bad++; $display("FAIL flush_kept_write got=%h want=1/0b/b1", wr_a); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy_before got=%b want=1", busy); end
    tick();
    flush = 1'b0;
    @(negedge clk);
    total++; if (wr_a.ready !== 1'b0 || wr_b.ready !== 1'b0) begin bad++; $display("FAIL flush_ports got a=%b b=%b want 0/0", wr_a.ready, wr_b.ready); end
    total++; if (busy !== 1'b0 || src_ready !== 4'b1111) begin bad++; $display("FAIL flush_after got busy=%b ready=%b want 0/1111", busy, src_ready); end
    total++; if (dut.rr !== 2'd2) begin bad++; $display("FAIL flush_rr got=%0d want=2", dut.rr); end
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    src_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin src_rd[i] = reg_num'(20 + i); src_value[i] = 32'hE0 + i; end
    tick();
    clear_inputs();
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (wr_a !== WB_IDLE || wr_b !== WB_IDLE || busy !== 1'b0 || src_ready !== 4'b1111) begin
      bad++; $display("FAIL mid_reset got a=%h b=%h busy=%b ready=%b want idle", wr_a, wr_b, busy, src_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    bit     m_occ[4];
    reg_num m_rd[4];
    word    m_val[4];
    int     m_rr;
    wb_line m_wa, m_wb;
    bit     n_occ[4];
    reg_num n_rd[4];
    word    n_val[4];
    int     n_rr;
    wb_line n_wa, n_wb;
    logic [3:0] exp_rdy;
    int     order[$];
    int     ga, gb;
    reg_num crd[4];
    word    cval[4];
    bit     taken[4];

    do_reset();
    for (int i = 0; i < 4; i++) begin m_occ[i] = 0; m_rd[i] = R0; m_val[i] = '0; end
    m_rr = 0; m_wa = WB_IDLE; m_wb = WB_IDLE;

    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      order.delete();
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_rr + k) % 4;
        crd[i]  = m_occ[i] ? m_rd[i]  : src_rd[i];
        cval[i] = m_occ[i] ? m_val[i] : src_value[i];
        if (m_occ[i] || (BYP && src_valid[i])) order.push_back(i);
      end
      ga = -1; gb = -1;
      if (!flush && order.size() > 0) begin
        ga = order[0];
        for (int j = 1; j < order.size(); j++)
          if (gb < 0 && crd[order[j]] != crd[ga]) gb = order[j];
      end
      for (int i = 0; i < 4; i++)
        exp_rdy[i] = !flush && (!m_occ[i] || i == ga || i == gb);

      total++; if (src_ready !== exp_rdy) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, src_ready, exp_rdy); end
      total++; if (busy !== (m_occ[0] | m_occ[1] | m_occ[2] | m_occ[3])) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b", cyc, busy); end
      total++; if (wr_a !== m_wa) begin bad++; $display("FAIL rand_wr_a cyc=%0d got=%h want=%h", cyc, wr_a, m_wa); end
      total++; if (wr_b !== m_wb) begin bad++; $display("FAIL rand_wr_b cyc=%0d got=%h want=%h", cyc, wr_b, m_wb); end

      n_wa = WB_IDLE; n_wb = WB_IDLE; n_rr = m_rr;
      if (ga >= 0) begin n_wa = '{1'b1, crd[ga], cval[ga]}; n_rr = (ga + 1) % 4; end
      if (gb >= 0) begin n_wb = '{1'b1, crd[gb], cval[gb]}; n_rr = (gb + 1) % 4; end
      for (int i = 0; i < 4; i++) begin
        bit granted;
        granted  = (i == ga || i == gb);
        taken[i] = src_valid[i] && exp_rdy[i];
        n_rd[i]  = m_rd[i];
        n_val[i] = m_val[i];
        if (flush) n_occ[i] = 0;
        else n_occ[i] = (m_occ[i] && !granted) || (taken[i] && !(!m_occ[i] && granted));
        if (taken[i] && !(!m_occ[i] && granted)) begin n_rd[i] = src_rd[i]; n_val[i] = src_value[i]; end
      end

      tick();
      m_occ = n_occ; m_rd = n_rd; m_val = n_val; m_rr = n_rr; m_wa = n_wa; m_wb = n_wb;

      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!src_valid[i] || taken[i]) begin
          src_valid[i] = ($urandom_range(0, 1) == 1);
          src_rd[i]    = reg_num'($urandom_range(0, 5));
          src_value[i] = $urandom;
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_rd_conflict();
    test_refill();
    test_flush();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
